// File: rtl/ibex_rf_access_ctrl.sv
// ibex_rf_access_ctrl: muxes core writeback with a halted-only external GPR access port, tracking write settle time.
// Define IBEX_RF_ACC_FWD_EN to forward unsettled write data to external reads instead of stalling them.
module ibex_rf_access_ctrl #(
    parameter int unsigned DataWidth    = 32,
    parameter bit          RV32E        = 1'b0,
    parameter int unsigned SettleCycles = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 core_halted_i,
    input  logic                 core_we_i,
    input  logic [4:0]           core_waddr_i,
    input  logic [DataWidth-1:0] core_wdata_i,
    input  logic [4:0]           core_raddr_a_i,
    input  logic                 ext_req_i,
    input  logic                 ext_we_i,
    input  logic [4:0]           ext_addr_i,
    input  logic [DataWidth-1:0] ext_wdata_i,
    output logic                 ext_gnt_o,
    output logic                 ext_rvalid_o,
    output logic [DataWidth-1:0] ext_rdata_o,
    output logic                 ext_err_o,
    output logic [4:0]           rf_raddr_a_o,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    output logic [4:0]           rf_waddr_a_o,
    output logic [DataWidth-1:0] rf_wdata_a_o,
    output logic                 rf_we_a_o,
    input  logic                 rf_err_i
);
    localparam int unsigned CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

    typedef enum logic [2:0] {IDLE, RD, WR, SETTLE, RESP} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [4:0]           addr_q, addr_d, last_q, last_d;
    logic [DataWidth-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 hazard, stall, addr_err, rf_write;
    logic                 fwd_q, fwd_d;
`ifdef IBEX_RF_ACC_FWD_EN
    logic [DataWidth-1:0] fwd_data_q, fwd_data_d;
`endif

    always_comb begin
        addr_err     = RV32E && ext_addr_i[4];
        hazard       = (cnt_q != '0) && (ext_addr_i == last_q);
`ifdef IBEX_RF_ACC_FWD_EN
        stall        = 1'b0;
`else
        stall        = hazard;
`endif
        ext_gnt_o    = ext_req_i && core_halted_i && (state_q == IDLE) && !core_we_i && !stall;
        // x0 writes complete the handshake but never strobe the RF
        rf_we_a_o    = (state_q == WR) ? (addr_q != 5'd0) : core_we_i;
        rf_waddr_a_o = (state_q == WR) ? addr_q : core_waddr_i;
        rf_wdata_a_o = (state_q == WR) ? wdata_q : core_wdata_i;
        rf_raddr_a_o = (state_q == RD && !fwd_q) ? addr_q : core_raddr_a_i;
        ext_rvalid_o = (state_q == RESP);
        ext_rdata_o  = ext_rvalid_o ? rdata_q : '0;
        ext_err_o    = ext_rvalid_o && err_q;
        rf_write     = (state_q == WR) || core_we_i;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fwd_d   = fwd_q;
        err_d   = err_q || (rf_err_i && (state_q == RD || state_q == WR || state_q == SETTLE))
                        || (core_we_i && state_q == WR);
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        last_d  = last_q;
`ifdef IBEX_RF_ACC_FWD_EN
        fwd_data_d = fwd_data_q;
        if (rf_write) fwd_data_d = rf_wdata_a_o;
`endif
        // Every RF write (external or core) restarts the settle window for its address
        if (rf_write) begin
            cnt_d  = CntW'(SettleCycles - 1);
            last_d = rf_waddr_a_o;
        end
        case (state_q)
            IDLE: if (ext_gnt_o) begin
                addr_d  = ext_addr_i;
                wdata_d = ext_wdata_i;
                rdata_d = '0;
                err_d   = addr_err;
                fwd_d   = hazard;
                state_d = addr_err ? RESP : (ext_we_i ? WR : RD);
            end
            RD: begin
`ifdef IBEX_RF_ACC_FWD_EN
                rdata_d = fwd_q ? fwd_data_q : rf_rdata_a_i;
`else
                rdata_d = rf_rdata_a_i;
`endif
                state_d = RESP;
            end
            WR:      state_d = SETTLE;
            SETTLE:  state_d = (cnt_q == '0) ? RESP : SETTLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            last_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            fwd_q   <= 1'b0;
`ifdef IBEX_RF_ACC_FWD_EN
            fwd_data_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            fwd_q   <= fwd_d;
`ifdef IBEX_RF_ACC_FWD_EN
            fwd_data_q <= fwd_data_d;
`endif
        end
    end
endmodule

// File: tb/tb_ibex_rf_access_ctrl.sv
// tb_ibex_rf_access_ctrl: directed bench with a small RF model; second instance built with RV32E=1.
module tb_ibex_rf_access_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_halted_i, core_we_i, ext_req_i, ext_we_i, rf_err_i;
    logic [4:0]  core_waddr_i, core_raddr_a_i, ext_addr_i;
    logic [31:0] core_wdata_i, ext_wdata_i;
    logic        ext_gnt_o, ext_rvalid_o, ext_err_o, rf_we_a_o;
    logic [31:0] ext_rdata_o, rf_rdata_a_i, rf_wdata_a_o;
    logic [4:0]  rf_raddr_a_o, rf_waddr_a_o;
    logic        gnt_e, rvalid_e, err_e, we_e;
    logic [31:0] rdata_e, rf_rdata_e, wdata_e;
    logic [4:0]  raddr_e, waddr_e;
    logic [31:0] mem [32];
    int          n_cmp = 0, n_bad = 0;
    int          wt, lat, wes;
    logic [31:0] d;
    logic        e;

    always #5 clk_i = ~clk_i;

    ibex_rf_access_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .core_halted_i(core_halted_i), .core_we_i(core_we_i),
        .core_waddr_i(core_waddr_i), .core_wdata_i(core_wdata_i), .core_raddr_a_i(core_raddr_a_i),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i), .ext_wdata_i(ext_wdata_i),
        .ext_gnt_o(ext_gnt_o), .ext_rvalid_o(ext_rvalid_o), .ext_rdata_o(ext_rdata_o), .ext_err_o(ext_err_o),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_rdata_a_i(rf_rdata_a_i), .rf_waddr_a_o(rf_waddr_a_o),
        .rf_wdata_a_o(rf_wdata_a_o), .rf_we_a_o(rf_we_a_o), .rf_err_i(rf_err_i)
    );

    ibex_rf_access_ctrl #(.RV32E(1'b1)) dut_e (
        .clk_i(clk_i), .rst_i(rst_i), .core_halted_i(core_halted_i), .core_we_i(core_we_i),
        .core_waddr_i(core_waddr_i), .core_wdata_i(core_wdata_i), .core_raddr_a_i(core_raddr_a_i),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i), .ext_wdata_i(ext_wdata_i),
        .ext_gnt_o(gnt_e), .ext_rvalid_o(rvalid_e), .ext_rdata_o(rdata_e), .ext_err_o(err_e),
        .rf_raddr_a_o(raddr_e), .rf_rdata_a_i(rf_rdata_e), .rf_waddr_a_o(waddr_e),
        .rf_wdata_a_o(wdata_e), .rf_we_a_o(we_e), .rf_err_i(rf_err_i)
    );

    always @(posedge clk_i) if (rf_we_a_o && rf_waddr_a_o != 5'd0) mem[rf_waddr_a_o] <= rf_wdata_a_o;
    assign rf_rdata_a_i = (rf_raddr_a_o == 5'd0) ? 32'd0 : mem[rf_raddr_a_o];
    assign rf_rdata_e   = (raddr_e == 5'd0) ? 32'd0 : mem[raddr_e];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts at a negedge, returns at a later negedge; all waits bounded.
    task automatic txn(input logic we, input logic [4:0] a, input logic [31:0] wd, input logic inj,
                       output int w, output int l, output int ws, output logic [31:0] rd, output logic er);
        ext_req_i = 1'b1; ext_we_i = we; ext_addr_i = a; ext_wdata_i = wd;
        w = 0; l = 0; ws = 0;
        #1;
        while (!ext_gnt_o && w < 20) begin @(negedge clk_i); #1; w++; end
        chk("gnt_bound", 32'(w < 20), 32'd1);
        @(negedge clk_i); ext_req_i = 1'b0; rf_err_i = inj; #1; l = 1;
        while (!ext_rvalid_o && l < 20) begin
            ws += int'(rf_we_a_o && rf_waddr_a_o == a);
            @(negedge clk_i); rf_err_i = 1'b0; #1; l++;
        end
        rd = ext_rdata_o; er = ext_err_o;
        @(negedge clk_i); rf_err_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; core_halted_i = 1'b0; core_we_i = 1'b0; ext_req_i = 1'b0; ext_we_i = 1'b0;
        rf_err_i = 1'b0; core_waddr_i = '0; core_raddr_a_i = '0; ext_addr_i = '0;
        core_wdata_i = '0; ext_wdata_i = '0;
        @(negedge clk_i); @(negedge clk_i); #1;
        chk("rst_gnt", 32'(ext_gnt_o), 0);
        chk("rst_rvalid", 32'(ext_rvalid_o), 0);
        chk("rst_rdata", ext_rdata_o, 0);
        chk("rst_err", 32'(ext_err_o), 0);
        chk("rst_we", 32'(rf_we_a_o), 0);
        @(negedge clk_i); rst_i = 1'b0; core_halted_i = 1'b1;
        core_we_i = 1'b1; core_waddr_i = 5'd5; core_wdata_i = 32'hDEADBEEF; #1;
        chk("core_we_pass", 32'(rf_we_a_o), 1);
        chk("core_waddr_pass", 32'(rf_waddr_a_o), 5);
        @(negedge clk_i); core_we_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i); core_raddr_a_i = 5'd17; #1;
        chk("raddr_pass", 32'(rf_raddr_a_o), 17);
        @(negedge clk_i);
        // plain read
        txn(1'b0, 5'd5, 0, 1'b0, wt, lat, wes, d, e);
        chk("rd5_wait", wt, 0); chk("rd5_lat", lat, 2); chk("rd5_data", d, 32'hDEADBEEF); chk("rd5_err", 32'(e), 0);
        #1 chk("rvalid_pulse", 32'(ext_rvalid_o), 0);
        @(negedge clk_i);
        // write then read back
        txn(1'b1, 5'd7, 32'h12345678, 1'b0, wt, lat, wes, d, e);
        chk("wr7_lat", lat, 4); chk("wr7_we_cnt", wes, 1); chk("wr7_rdata", d, 0); chk("wr7_err", 32'(e), 0);
        txn(1'b0, 5'd7, 0, 1'b0, wt, lat, wes, d, e);
        chk("rd7_data", d, 32'h12345678);
        // x0 write suppressed
        txn(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, wt, lat, wes, d, e);
        chk("wr0_we_cnt", wes, 0); chk("wr0_lat", lat, 4); chk("wr0_err", 32'(e), 0);
        txn(1'b0, 5'd0, 0, 1'b0, wt, lat, wes, d, e);
        chk("rd0_data", d, 0);
        // not halted: no grant
        core_halted_i = 1'b0; ext_req_i = 1'b1; ext_we_i = 1'b0; ext_addr_i = 5'd5; #1;
        chk("nohalt_gnt", 32'(ext_gnt_o), 0);
        @(negedge clk_i); core_halted_i = 1'b1;
        // core writeback wins, then RAW hazard on the same address
        core_we_i = 1'b1; core_waddr_i = 5'd3; core_wdata_i = 32'hCAFE0003; ext_addr_i = 5'd3; #1;
        chk("core_wins_gnt", 32'(ext_gnt_o), 0);
        chk("core_wins_waddr", 32'(rf_waddr_a_o), 3);
        @(negedge clk_i); #1;
        chk("core_wins_gnt2", 32'(ext_gnt_o), 0);
        @(negedge clk_i); core_we_i = 1'b0;
        txn(1'b0, 5'd3, 0, 1'b0, wt, lat, wes, d, e);
`ifdef IBEX_RF_ACC_FWD_EN
        chk("hazard_wait", wt, 0);
`else
        chk("hazard_wait", wt, 1);
`endif
        chk("hazard_lat", lat, 2); chk("hazard_data", d, 32'hCAFE0003);
        // RF integrity error during RD
        txn(1'b0, 5'd5, 0, 1'b1, wt, lat, wes, d, e);
        chk("rferr_err", 32'(e), 1); chk("rferr_data", d, 32'hDEADBEEF);
        // core write during WR is dropped and flagged
        ext_req_i = 1'b1; ext_we_i = 1'b1; ext_addr_i = 5'd10; ext_wdata_i = 32'hA5A50000; #1;
        chk("viol_gnt", 32'(ext_gnt_o), 1);
        @(negedge clk_i); ext_req_i = 1'b0; core_we_i = 1'b1; core_waddr_i = 5'd11; core_wdata_i = 32'h11; #1;
        chk("viol_waddr", 32'(rf_waddr_a_o), 10);
        chk("viol_wdata", rf_wdata_a_o, 32'hA5A50000);
        @(negedge clk_i); core_we_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i); #1;
        chk("viol_rvalid", 32'(ext_rvalid_o), 1);
        chk("viol_err", 32'(ext_err_o), 1);
        @(negedge clk_i);
        txn(1'b0, 5'd10, 0, 1'b0, wt, lat, wes, d, e);
        chk("viol_rd10", d, 32'hA5A50000);
        // reset during SETTLE aborts without a response
        ext_req_i = 1'b1; ext_we_i = 1'b1; ext_addr_i = 5'd12; ext_wdata_i = 32'h0C0C0C0C; #1;
        chk("rstmid_gnt", 32'(ext_gnt_o), 1);
        @(negedge clk_i); ext_req_i = 1'b0;
        @(negedge clk_i); rst_i = 1'b1; #1;
        chk("rstmid_rvalid", 32'(ext_rvalid_o), 0);
        chk("rstmid_we", 32'(rf_we_a_o), 0);
        chk("rstmid_rdata", ext_rdata_o, 0);
        @(negedge clk_i); rst_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i); #1;
        chk("rstmid_noresp", 32'(ext_rvalid_o), 0);
        @(negedge clk_i);
        txn(1'b0, 5'd12, 0, 1'b0, wt, lat, wes, d, e);
        chk("rstmid_rd_lat", lat, 2); chk("rstmid_rd_data", d, 32'h0C0C0C0C);
        // RV32E out-of-range address on the second instance
        ext_req_i = 1'b1; ext_we_i = 1'b0; ext_addr_i = 5'd20; #1;
        chk("e_gnt", 32'(gnt_e), 1);
        @(negedge clk_i); ext_req_i = 1'b0; #1;
        chk("e_rvalid", 32'(rvalid_e), 1);
        chk("e_err", 32'(err_e), 1);
        chk("e_rdata", rdata_e, 0);
        chk("e_raddr", 32'(raddr_e), 17);
        chk("i_raddr_rd", 32'(rf_raddr_a_o), 20);
        @(negedge clk_i); #1;
        chk("i_rvalid", 32'(ext_rvalid_o), 1);
        chk("i_err", 32'(ext_err_o), 0);
        @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
